rename_map_table: RTL and testbench

Parametrised register-alias (map) table for the out-of-order OTTER front end. It tracks which reservation-station tag will produce each architectural register. Sources are translated to tags at issue, and a new tag is recorded for the destination. Entries retire from N common-data-bus (CDB) ports, and each retirement produces a registered register-file write. Sits between decode/issue and the reservation stations and register file; supports multi-CDB, same-cycle CDB forwarding, occupancy reporting and a global flush.

---
 rtl/rename_map_table.sv | 179 +++++++++++++++++
 tb/tb_rename_map_table.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
`default_nettype none
// ============================================================================
// Module : rename_map_table
// Register-alias table: maps architectural registers to RS tags, retires
// mappings from the CDB ports and emits registered register-file writes.
// Rev    : 1.0
// ============================================================================
module rename_map_table #(
  parameter int  NUM_REGS = 32,
  parameter int  TAG_W    = 4,
  parameter int  NUM_SRC  = 3,
  parameter int  NUM_CDB  = 2,
  parameter int  XLEN     = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_rd_we,
  input  logic [RA_W-1:0]           issue_rd,
  input  logic [TAG_W-1:0]          issue_tag,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*RA_W-1:0]   src_addr,
  output logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_fwd_valid,
  output logic [NUM_SRC*XLEN-1:0]   src_fwd_data,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]   cdb_data,
  output logic [NUM_CDB-1:0]        rf_we,
  output logic [NUM_CDB*RA_W-1:0]   rf_waddr,
  output logic [NUM_CDB*XLEN-1:0]   rf_wdata,
  output logic [RA_W:0]             busy_count
);

  logic [NUM_REGS-1:0]      r_busy;
  logic [TAG_W-1:0]         r_tag [NUM_REGS];
  logic [NUM_CDB-1:0]       r_rf_we;
  logic [NUM_CDB*RA_W-1:0]  r_rf_waddr;
  logic [NUM_CDB*XLEN-1:0]  r_rf_wdata;
  logic [RA_W:0]            r_busy_count;

  logic [NUM_REGS-1:0]      w_busy_nxt;
  logic [TAG_W-1:0]         w_tag_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]      w_ret_hit [NUM_CDB];
  logic [NUM_CDB-1:0]       w_rf_we;
  logic [RA_W-1:0]          w_rf_addr [NUM_CDB];
  logic [RA_W:0]            w_busy_cnt;
  logic                     w_issue;
  logic                     w_dup_cdb;

  assign w_issue = issue_valid & issue_rd_we & (issue_rd != '0);

  always_comb begin : retire_match
    for (int p = 0; p < NUM_CDB; p++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w_ret_hit[p][i] = cdb_valid[p] & r_busy[i] &
                          (r_tag[i] == cdb_tag[p*TAG_W +: TAG_W]);
      end
    end
  end

  // Priority inside an entry: retire < issue < flush.
  always_comb begin : next_state
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_tag_nxt[i] = r_tag[i];
      for (int p = 0; p < NUM_CDB; p++) begin
        if (w_ret_hit[p][i]) begin
          w_busy_nxt[i] = 1'b0;
          w_tag_nxt[i]  = '0;
        end
      end
      if (w_issue && (issue_rd == RA_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
        w_tag_nxt[i]  = issue_tag;
      end
      if (flush) begin
        w_busy_nxt[i] = 1'b0;
        w_tag_nxt[i]  = '0;
      end
    end
  end

  // A retiring value whose register is re-renamed this cycle is dead.
  always_comb begin : retire_ports
    w_rf_we = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      w_rf_addr[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ret_hit[p][i] && !(w_issue && (issue_rd == RA_W'(i)))) begin
          w_rf_we[p]   = 1'b1;
          w_rf_addr[p] = RA_W'(i);
        end
      end
      if (flush) begin
        w_rf_we[p] = 1'b0;
      end
    end
  end

  always_comb begin : occupancy
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy_cnt = w_busy_cnt + {{RA_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_comb begin : lookup
    src_tag       = '0;
    src_fwd_valid = '0;
    src_fwd_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_used[k] && r_busy[src_addr[k*RA_W +: RA_W]]) begin
        src_tag[k*TAG_W +: TAG_W] = r_tag[src_addr[k*RA_W +: RA_W]];
        for (int p = 0; p < NUM_CDB; p++) begin
          if (cdb_valid[p] &&
              (cdb_tag[p*TAG_W +: TAG_W] == r_tag[src_addr[k*RA_W +: RA_W]])) begin
            src_tag[k*TAG_W +: TAG_W]   = '0;
            src_fwd_valid[k]            = 1'b1;
            src_fwd_data[k*XLEN +: XLEN] = cdb_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= '0;
      end
      r_rf_we      <= '0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= w_tag_nxt[i];
      end
      r_rf_we <= w_rf_we;
      for (int p = 0; p < NUM_CDB; p++) begin
        if (w_rf_we[p]) begin
          r_rf_waddr[p*RA_W +: RA_W]   <= w_rf_addr[p];
          r_rf_wdata[p*XLEN +: XLEN]   <= cdb_data[p*XLEN +: XLEN];
        end
      end
      r_busy_count <= w_busy_cnt;
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign busy_count = r_busy_count;

  always_comb begin : dup_check
    w_dup_cdb = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      for (int q = p + 1; q < NUM_CDB; q++) begin
        if (cdb_valid[p] && cdb_valid[q] &&
            (cdb_tag[p*TAG_W +: TAG_W] == cdb_tag[q*TAG_W +: TAG_W])) begin
          w_dup_cdb = 1'b1;
        end
      end
    end
  end

  a_issue_tag_nonzero : assert property (@(posedge CLK) disable iff (!RST_N)
    !(issue_valid && issue_rd_we && (issue_tag == '0)));

  a_cdb_tags_unique : assert property (@(posedge CLK) disable iff (!RST_N)
    !w_dup_cdb);

endmodule
`default_nettype wire

// File: tb/tb_rename_map_table.sv
`default_nettype none
// Bench for rename_map_table: directed scenarios plus randomized traffic
// checked against a register->tag map model (tag 0 means not busy).
module tb_rename_map_table;
  localparam int NR = 32, TW = 4, NS = 3, NC = 2, XL = 32, RA = 5;

  logic CLK = 1'b0, RST_N = 1'b0, flush = 1'b0;
  logic issue_valid = 1'b0, issue_rd_we = 1'b0;
  logic [RA-1:0]    issue_rd = '0;
  logic [TW-1:0]    issue_tag = '0;
  logic [NS-1:0]    src_used = '0;
  logic [NS*RA-1:0] src_addr = '0;
  logic [NS*TW-1:0] src_tag;
  logic [NS-1:0]    src_fwd_valid;
  logic [NS*XL-1:0] src_fwd_data;
  logic [NC-1:0]    cdb_valid = '0;
  logic [NC*TW-1:0] cdb_tag = '0;
  logic [NC*XL-1:0] cdb_data = '0;
  logic [NC-1:0]    rf_we;
  logic [NC*RA-1:0] rf_waddr;
  logic [NC*XL-1:0] rf_wdata;
  logic [RA:0]      busy_count;

  int total = 0, bad = 0;
  int m_tag [NR];
  logic [NC-1:0] e_we;
  logic [RA-1:0] e_addr [NC];
  logic [XL-1:0] e_data [NC];

  rename_map_table #(.NUM_REGS(NR), .TAG_W(TW), .NUM_SRC(NS), .NUM_CDB(NC), .XLEN(XL)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .issue_valid(issue_valid), .issue_rd_we(issue_rd_we), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .src_used(src_used), .src_addr(src_addr), .src_tag(src_tag),
    .src_fwd_valid(src_fwd_valid), .src_fwd_data(src_fwd_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_count(busy_count)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    flush = 1'b0; issue_valid = 1'b0; issue_rd_we = 1'b0; issue_rd = '0; issue_tag = '0;
    src_used = '0; src_addr = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < NR; r++) if (m_tag[r] != 0) c++;
    return c;
  endfunction

  // Advance one clock: derive expected rf writes from the map, then update the map.
  task automatic tick();
    int nt [NR];
    for (int r = 0; r < NR; r++) nt[r] = m_tag[r];
    e_we = '0;
    for (int p = 0; p < NC; p++) begin
      e_addr[p] = '0; e_data[p] = '0;
      if (cdb_valid[p] && !flush) begin
        for (int r = 1; r < NR; r++) begin
          if (m_tag[r] != 0 && m_tag[r] == int'(cdb_tag[p*TW +: TW])) begin
            nt[r] = 0;
            if (!(issue_valid && issue_rd_we && int'(issue_rd) == r)) begin
              e_we[p] = 1'b1; e_addr[p] = RA'(r); e_data[p] = cdb_data[p*XL +: XL];
            end
          end
        end
      end
    end
    if (issue_valid && issue_rd_we && issue_rd != 0) nt[issue_rd] = int'(issue_tag);
    if (flush) for (int r = 0; r < NR; r++) nt[r] = 0;
    @(posedge CLK); #1;
    for (int r = 0; r < NR; r++) m_tag[r] = nt[r];
  endtask

  task automatic issue(input int rd, input int tag);
    issue_valid = 1'b1; issue_rd_we = 1'b1; issue_rd = RA'(rd); issue_tag = TW'(tag);
  endtask

  task automatic test_reset();
    for (int r = 0; r < NR; r++) m_tag[r] = 0;
    idle(); RST_N = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    src_used = 3'b001; src_addr[4:0] = 5'd5; #1;
    total++; if (src_tag[3:0] !== 4'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", src_tag[3:0]); end
    total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy_count); end
    total++; if (rf_we !== 2'b00 || rf_waddr !== '0 || rf_wdata !== '0) begin
      bad++; $display("FAIL reset_rf: we=%b addr=%h data=%h want zeros", rf_we, rf_waddr, rf_wdata); end
    RST_N = 1'b1; idle();
  endtask

  task automatic test_basic();
    idle(); issue(5, 3); tick(); idle();
    src_used = 3'b001; src_addr[4:0] = 5'd5; #1;
    total++; if (src_tag[3:0] !== 4'd3 || src_fwd_valid[0] !== 1'b0) begin
      bad++; $display("FAIL basic_lookup: tag=%0d fwd=%b want 3/0", src_tag[3:0], src_fwd_valid[0]); end
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd3; cdb_data[31:0] = 32'hDEADBEEF; #1;
    total++; if (src_tag[3:0] !== 4'd0 || src_fwd_valid[0] !== 1'b1 || src_fwd_data[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_fwd: tag=%0d fwd=%b data=%h want 0/1/deadbeef", src_tag[3:0], src_fwd_valid[0], src_fwd_data[31:0]); end
    tick(); idle();
    total++; if (rf_we !== 2'b01 || rf_waddr[4:0] !== 5'd5 || rf_wdata[31:0] !== 32'hDEADBEEF || busy_count !== 6'd0) begin
      bad++; $display("FAIL basic_write: we=%b addr=%0d data=%h busy=%0d want 01/5/deadbeef/0", rf_we, rf_waddr[4:0], rf_wdata[31:0], busy_count); end
    tick();
    total++; if (rf_we !== 2'b00) begin bad++; $display("FAIL basic_we_pulse: got %b want 00", rf_we); end
  endtask

  task automatic test_rename_twice();
    idle(); issue(7, 2); tick(); issue(7, 4); tick(); idle();
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd2; cdb_data[31:0] = 32'h11; tick(); idle();
    src_used = 3'b010; src_addr[9:5] = 5'd7; #1;
    total++; if (rf_we !== 2'b00 || src_tag[7:4] !== 4'd4) begin
      bad++; $display("FAIL rename_stale: we=%b tag=%0d want 00/4", rf_we, src_tag[7:4]); end
    cdb_valid = 2'b10; cdb_tag[7:4] = 4'd4; cdb_data[63:32] = 32'h22; tick(); idle();
    total++; if (rf_we !== 2'b10 || rf_waddr[9:5] !== 5'd7 || rf_wdata[63:32] !== 32'h22) begin
      bad++; $display("FAIL rename_write: we=%b addr=%0d data=%h want 10/7/22", rf_we, rf_waddr[9:5], rf_wdata[63:32]); end
  endtask

  task automatic test_issue_vs_retire();
    idle(); issue(9, 1); tick();
    issue(9, 6); cdb_valid = 2'b01; cdb_tag[3:0] = 4'd1; cdb_data[31:0] = 32'h99; tick(); idle();
    src_used = 3'b100; src_addr[14:10] = 5'd9; #1;
    total++; if (rf_we !== 2'b00 || src_tag[11:8] !== 4'd6 || busy_count !== 6'd1) begin
      bad++; $display("FAIL issue_wins: we=%b tag=%0d busy=%0d want 00/6/1", rf_we, src_tag[11:8], busy_count); end
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd6; tick(); idle();
  endtask

  task automatic test_dual_cdb();
    idle(); issue(1, 1); tick(); issue(2, 2); tick(); idle();
    total++; if (busy_count !== 6'd2) begin bad++; $display("FAIL dual_pre_busy: got %0d want 2", busy_count); end
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd1}; cdb_data = {32'hBBBB0002, 32'hAAAA0001}; tick(); idle();
    total++; if (rf_we !== 2'b11 || rf_waddr !== {5'd2, 5'd1} || rf_wdata !== {32'hBBBB0002, 32'hAAAA0001} || busy_count !== 6'd0) begin
      bad++; $display("FAIL dual_write: we=%b addr=%h data=%h busy=%0d", rf_we, rf_waddr, rf_wdata, busy_count); end
  endtask

  task automatic test_x0_and_flush();
    idle(); issue(0, 5); tick(); idle();
    src_used = 3'b001; src_addr[4:0] = 5'd0; #1;
    total++; if (busy_count !== 6'd0 || src_tag[3:0] !== 4'd0) begin
      bad++; $display("FAIL x0_busy: busy=%0d tag=%0d want 0/0", busy_count, src_tag[3:0]); end
    for (int i = 0; i < 4; i++) begin issue(10 + i, 7 + i); tick(); end
    idle();
    total++; if (busy_count !== 6'd4) begin bad++; $display("FAIL flush_pre: busy=%0d want 4", busy_count); end
    flush = 1'b1; cdb_valid = 2'b01; cdb_tag[3:0] = 4'd7; issue(14, 12); tick(); idle();
    src_used = 3'b111; src_addr = {5'd12, 5'd11, 5'd10}; #1;
    total++; if (busy_count !== 6'd0 || rf_we !== 2'b00 || src_tag !== '0 || src_fwd_valid !== '0) begin
      bad++; $display("FAIL flush: busy=%0d we=%b tags=%h fwd=%b want 0/00/0/0", busy_count, rf_we, src_tag, src_fwd_valid); end
  endtask

  task automatic test_async_reset();
    idle(); issue(20, 3); tick(); issue(21, 5); tick(); idle();
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd3; cdb_data[31:0] = 32'h5555;
    #2 RST_N = 1'b0; #1;
    for (int r = 0; r < NR; r++) m_tag[r] = 0;
    src_used = 3'b001; src_addr[4:0] = 5'd21; #1;
    total++; if (busy_count !== 6'd0 || src_tag[3:0] !== 4'd0) begin
      bad++; $display("FAIL async_reset: busy=%0d tag=%0d want 0/0", busy_count, src_tag[3:0]); end
    @(posedge CLK); #1;
    total++; if (rf_we !== 2'b00) begin bad++; $display("FAIL async_reset_we: got %b want 00", rf_we); end
    RST_N = 1'b1; idle();
  endtask

  function automatic int pick_free_tag();
    int cand [$];
    for (int t = 1; t < 16; t++) begin
      bit used = 1'b0;
      for (int r = 0; r < NR; r++) if (m_tag[r] == t) used = 1'b1;
      if (!used) cand.push_back(t);
    end
    if (cand.size() == 0) return 0;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  function automatic int pick_cdb_tag();
    int cand [$];
    for (int r = 0; r < NR; r++) if (m_tag[r] != 0) cand.push_back(m_tag[r]);
    if (cand.size() == 0 || $urandom_range(3) == 0) return 1 + int'($urandom_range(14));
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic test_random();
    int t, a, et, ef;
    logic [XL-1:0] ed;
    idle(); flush = 1'b1; tick(); idle();
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(2) != 0) begin
        t = pick_free_tag();
        if (t != 0) begin
          issue_valid = 1'b1; issue_rd_we = ($urandom_range(3) != 0);
          issue_rd = RA'($urandom_range(NR - 1)); issue_tag = TW'(t);
        end
      end
      for (int p = 0; p < NC; p++) begin
        if ($urandom_range(1) == 1) begin
          cdb_valid[p] = 1'b1; cdb_tag[p*TW +: TW] = TW'(pick_cdb_tag()); cdb_data[p*XL +: XL] = $urandom;
        end
      end
      if (cdb_valid == 2'b11 && cdb_tag[3:0] == cdb_tag[7:4]) cdb_valid[1] = 1'b0;
      flush = ($urandom_range(39) == 0);
      src_used = NS'($urandom); src_addr = NS*RA'($urandom);
      #1;
      for (int k = 0; k < NS; k++) begin
        a = int'(src_addr[k*RA +: RA]); et = 0; ef = 0; ed = '0;
        if (src_used[k] && m_tag[a] != 0) begin
          et = m_tag[a];
          for (int p = 0; p < NC; p++)
            if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == m_tag[a]) begin et = 0; ef = 1; ed = cdb_data[p*XL +: XL]; end
        end
        total++;
        if (src_tag[k*TW +: TW] !== TW'(et) || src_fwd_valid[k] !== ef[0] || (ef == 1 && src_fwd_data[k*XL +: XL] !== ed)) begin
          bad++; $display("FAIL rand_lookup[%0d] cyc %0d: tag=%0d fwd=%b data=%h want %0d/%0d/%h",
                          k, n, src_tag[k*TW +: TW], src_fwd_valid[k], src_fwd_data[k*XL +: XL], et, ef, ed);
        end
      end
      tick();
      for (int p = 0; p < NC; p++) begin
        total++;
        if (rf_we[p] !== e_we[p] || (e_we[p] && (rf_waddr[p*RA +: RA] !== e_addr[p] || rf_wdata[p*XL +: XL] !== e_data[p]))) begin
          bad++; $display("FAIL rand_rf[%0d] cyc %0d: we=%b addr=%0d data=%h want %b/%0d/%h",
                          p, n, rf_we[p], rf_waddr[p*RA +: RA], rf_wdata[p*XL +: XL], e_we[p], e_addr[p], e_data[p]);
        end
      end
      total++;
      if (busy_count !== (RA+1)'(model_count())) begin
        bad++; $display("FAIL rand_busy cyc %0d: got %0d want %0d", n, busy_count, model_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rename_twice();
    test_issue_vs_retire();
    test_dual_cdb();
    test_x0_and_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
